// File: rtl/bk_add_arb_pkg.sv
// Shared types and defaults for the round-robin arbitrated Brent-Kung adder.
package bk_add_arb_pkg;

    // Default sizing: four requesters sharing a 16-bit adder
    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 16;

    // Arbiter/adder sequencing: accept in IDLE, add in CALC, present in HOLD
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of a requester index; at least one bit even for a single requester
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bk_add_arb_bk_adder.sv
// BK_Adder: purely combinational Brent-Kung parallel-prefix adder.
// Carry-in is folded into the bit-0 generate so the prefix tree yields every carry.
module BK_Adder #(
    parameter int W = 16
) (
    output logic [W-1:0] s,
    output logic         cout,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin
);

    // Largest power of two below W: first span used by the down-sweep
    localparam int TOPD = (W > 1) ? (1 << ($clog2(W) - 1)) : 1;

    logic [W-1:0] gg;
    logic [W-1:0] pp;
    logic [W-1:0] prop;
    logic [W-1:0] carry;

    // Up-sweep builds power-of-two spans, down-sweep fills in the remaining prefixes
    always_comb begin
        prop  = a ^ b;
        gg    = a & b;
        pp    = prop;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int d = 1; d < W; d = d * 2) begin
            for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = TOPD; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        carry = {gg[W-2:0], cin};
        s     = prop ^ carry;
        cout  = gg[W-1];
    end

endmodule

// File: rtl/bk_add_arb.sv
// bk_add_arb: NREQ requesters share one Brent-Kung adder through a
// round-robin arbiter; one operation in flight, result held until taken.
module bk_add_arb
    import bk_add_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int W    = W_DEF,
    localparam int IDW  = idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IDW-1:0]    rsp_id
);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   last_grant;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic             xfer;

    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic             sel_cin;

    logic [W-1:0]     a_p0;
    logic [W-1:0]     b_p0;
    logic             cin_p0;
    logic [IDW-1:0]   id_p0;

    logic [W-1:0]     add_s;
    logic             add_cout;

    logic [W-1:0]     sum_p1;
    logic             cout_p1;
    logic [IDW-1:0]   id_p1;
    logic             vld_p1;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        logic [IDW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_grant) + k) % NREQ);
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // Accept strobe only while idle; held low throughout reset
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // The grant only selects a valid requester, so a grant in IDLE is a transfer
    assign xfer = (state == IDLE) && gnt_vld;

    // Operand mux for the granted requester
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_cin = req_cin[i];
            end
        end
    end

    // Next-state sequencing: IDLE -> CALC -> HOLD -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = CALC;
            CALC:    state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- stage p0: capture granted operands and advance the pointer ----
    // Pointer starts at NREQ-1 so requester 0 wins first after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0       <= '0;
            b_p0       <= '0;
            cin_p0     <= 1'b0;
            id_p0      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (xfer) begin
            a_p0       <= sel_a;
            b_p0       <= sel_b;
            cin_p0     <= sel_cin;
            id_p0      <= gnt_idx;
            last_grant <= gnt_idx;
        end
    end

    BK_Adder #(.W(W)) u_adder (
        .s    (add_s),
        .cout (add_cout),
        .a    (a_p0),
        .b    (b_p0),
        .cin  (cin_p0)
    );

    // ---- stage p1: register the sum during CALC and hold it through HOLD ----
    // Result registers load only in CALC so they stay stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            id_p1   <= '0;
        end else if (state == CALC) begin
            sum_p1  <= add_s;
            cout_p1 <= add_cout;
            id_p1   <= id_p0;
        end
    end

    // Response valid rises with the registered result, drops when it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (state == CALC) begin
            vld_p1 <= 1'b1;
        end else if ((state == HOLD) && rsp_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_sum   = sum_p1;
    assign rsp_cout  = cout_p1;
    assign rsp_id    = id_p1;

endmodule
